// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction in a separate FIX cycle, results held until the next FIX.
module div_unit #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] div_dividend,
  input  logic [DIV_W-1:0] div_divisor,
  input  logic             div_cancel,
  output logic             div_ready,
  output logic             div_busy,
  output logic             div_done,
  output logic [DIV_W-1:0] div_quotient,
  output logic [DIV_W-1:0] div_remainder
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [DIV_W-1:0] dividend_mag;
  logic [DIV_W-1:0] divisor_mag;
  logic [DIV_W:0]   rem_shift;
  logic [DIV_W-1:0] diff;
  logic             fits;

  assign div_ready = (state == IDLE);
  assign div_busy  = (state != IDLE);
  assign div_done  = (state == DONE);
  assign accept    = div_valid & div_ready & ~div_cancel;

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  assign dividend_neg = div_signed & div_dividend[DIV_W-1];
  assign divisor_neg  = div_signed & div_divisor[DIV_W-1];
  assign dividend_mag = dividend_neg ? (~div_dividend + DIV_W'(1)) : div_dividend;
  assign divisor_mag  = divisor_neg  ? (~div_divisor  + DIV_W'(1)) : div_divisor;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem, quo[DIV_W-1]};
  assign fits      = (rem_shift >= {1'b0, dvs});
  assign diff      = DIV_W'(rem_shift - {1'b0, dvs});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (div_cancel)              state_nxt = IDLE;
        else if (cnt == LAST_ITER)   state_nxt = FIX;
      end
      FIX:  state_nxt = div_cancel ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      quo           <= '0;
      dvs           <= '0;
      rem           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo   <= dividend_mag;
            dvs   <= divisor_mag;
            rem   <= '0;
            q_neg <= dividend_neg ^ divisor_neg;
            r_neg <= dividend_neg;
            cnt   <= '0;
          end
        end
        CALC: begin
          rem <= fits ? diff : rem_shift[DIV_W-1:0];
          quo <= {quo[DIV_W-2:0], fits};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          // A flush here must leave the previous result visible.
          if (!div_cancel) begin
            div_quotient  <= q_neg ? (~quo + DIV_W'(1)) : quo;
            div_remainder <= r_neg ? (~rem + DIV_W'(1)) : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboarded results, latency, flush,
// asynchronous reset and back-to-back acceptance.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_valid;
  logic         div_signed;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_cancel;
  logic         div_ready;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  always #5 clk = ~clk;

  div_unit #(.DIV_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_valid    (div_valid),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_cancel   (div_cancel),
    .div_ready    (div_ready),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  // Reference result built from plain division on magnitudes.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic         an, bn;
    logic [W-1:0] am, bm, qm, rm, q, r;
    an = sgn & a[W-1];
    bn = sgn & b[W-1];
    am = an ? (32'd0 - a) : a;
    bm = bn ? (32'd0 - b) : b;
    if (bm == 32'd0) begin
      qm = 32'hFFFF_FFFF;
      rm = am;
    end else begin
      qm = am / bm;
      rm = am % bm;
    end
    q = (an ^ bn) ? (32'd0 - qm) : qm;
    r = an ? (32'd0 - rm) : rm;
    return {q, r};
  endfunction

  // Present a request for one cycle; returns at the sample point right after the accept edge.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    n_cmp++;
    if (div_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_req: div_ready=%b required 1", div_ready);
    end
    div_valid    = 1'b1;
    div_signed   = sgn;
    div_dividend = a;
    div_divisor  = b;
    @(negedge clk);
    div_valid    = 1'b0;
    div_signed   = ~sgn;
    div_dividend = $urandom;
    div_divisor  = $urandom;
  endtask

  // Wait for div_done, pop the scoreboard and check value, latency and busy span.
  task automatic finish_op(input string name);
    int   busy_cnt;
    int   k_done;
    logic seen;
    logic [W-1:0] eq, er;
    busy_cnt = 0;
    k_done   = -1;
    seen     = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (div_busy) busy_cnt++;
      if (div_done) begin
        seen   = 1'b1;
        k_done = k;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s: done with empty scoreboard", name);
        end else begin
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          if (div_quotient !== eq || div_remainder !== er) begin
            n_err++;
            $display("FAIL %s: got q=%h r=%h required q=%h r=%h",
                     name, div_quotient, div_remainder, eq, er);
          end
          last_q = eq;
          last_r = er;
        end
      end
    end
    n_cmp++;
    if (!seen || k_done != 33) begin
      n_err++;
      $display("FAIL %s_latency: done at cycle %0d after accept, required 33", name, k_done);
    end
    n_cmp++;
    if (busy_cnt != 34) begin
      n_err++;
      $display("FAIL %s_busy: busy for %0d cycles, required 34", name, busy_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (div_ready !== 1'b1 || div_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_after: ready=%b done=%b required ready=1 done=0", name, div_ready, div_done);
    end
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r);
    exp_q.push_back(q);
    exp_r.push_back(r);
    start_op(sgn, a, b);
    finish_op(name);
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (div_ready !== 1'b1 || div_busy !== 1'b0 || div_done !== 1'b0 ||
        div_quotient !== '0 || div_remainder !== '0) begin
      n_err++;
      $display("FAIL %s: ready=%b busy=%b done=%b q=%h r=%h required 1 0 0 0 0",
               name, div_ready, div_busy, div_done, div_quotient, div_remainder);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    div_valid    = 1'b0;
    div_signed   = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    div_cancel   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_basic();
    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
  endtask

  task automatic test_signed();
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
  endtask

  task automatic test_boundary();
    run_op("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("udiv_7_0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    run_op("sdiv_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'd1, 32'hFFFF_FFF9);
  endtask

  task automatic test_random();
    logic [2*W-1:0] m;
    logic [W-1:0]   a, b;
    logic           s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? W'($urandom_range(1, 1000)) : W'($urandom);
      s = i[0];
      m = model(s, a, b);
      run_op("random", s, a, b, m[2*W-1:W], m[W-1:0]);
    end
  endtask

  task automatic test_cancel();
    logic bad;
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (div_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cancel_ready: div_ready=%b required 1", div_ready);
    end
    div_cancel = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (div_done !== 1'b0 || div_quotient !== last_q || div_remainder !== last_r) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL cancel_hold: done=%b q=%h r=%h required done=0 q=%h r=%h",
               div_done, div_quotient, div_remainder, last_q, last_r);
    end
    // Flush wins over a simultaneous request in IDLE.
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_priority: div_busy=%b required 0", div_busy);
    end
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    run_op("udiv_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
  endtask

  task automatic test_async_reset();
    logic bad;
    start_op(1'b0, 32'd12345, 32'd6);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (div_done !== 1'b0 || div_busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_no_done: done=%b busy=%b required 0 0", div_done, div_busy);
    end
    last_q = '0;
    last_r = '0;
  endtask

  task automatic test_back_to_back();
    int   acc_cyc[$];
    logic prev_busy;
    logic [W-1:0] eq, er;
    @(negedge clk);
    div_valid    = 1'b1;
    div_signed   = 1'b0;
    div_dividend = 32'd50;
    div_divisor  = 32'd5;
    prev_busy    = div_busy;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (div_busy && !prev_busy) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(32'd10);
        exp_r.push_back(32'd0);
        if (acc_cyc.size() == 4) div_valid = 1'b0;
      end
      if (div_done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_result: done with empty scoreboard");
        end else begin
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          if (div_quotient !== eq || div_remainder !== er) begin
            n_err++;
            $display("FAIL b2b_result: got q=%h r=%h required q=%h r=%h",
                     div_quotient, div_remainder, eq, er);
          end
        end
      end
      prev_busy = div_busy;
    end
    div_valid = 1'b0;
    n_cmp++;
    if (acc_cyc.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count: %0d accepts, required 4", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[i-1] != 35) begin
        n_err++;
        $display("FAIL b2b_interval: %0d cycles between accepts, required 35",
                 acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_boundary();
    test_random();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
